load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's memory-access stage and data_memory.
- Converts byte, halfword and word load/store requests into word-only memory transactions.
- Sub-word stores use read-modify-write: read the word, merge the new lane, write it back.
- Load data is lane-extracted and sign- or zero-extended.
- Misaligned and out-of-range requests are flagged without touching memory.

Parameters:
- MEM_WORDS, 1024: data memory depth in 32-bit words. Valid byte addresses are 0 to MEM_WORDS*4-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and for errors.
- resp_misaligned  out  1  valid with resp_valid.
- resp_out_of_range  out  1  valid with resp_valid.
- mem_read  out  1  to data_memory.
- mem_write  out  1  to data_memory.
- mem_address  out  32  word-aligned address to data_memory ([1:0] = 00).
- mem_write_data  out  32  to data_memory.
- mem_read_data  in  32  combinational read data from data_memory.

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset (synchronous) forces IDLE and clears all registers. While in IDLE: req_ready=1, resp_valid=0, resp_rdata=0, both flags 0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- req_ready=1 only in IDLE. A request is accepted on an edge where req_valid and req_ready are both 1. Accepting latches addr, wdata, size, write and unsigned. Inputs are ignored in every other state.
- Error checks at acceptance:
  - misaligned: half with addr[0]=1; word with addr[1:0]!=00; size 11 always.
  - out_of_range: addr >= MEM_WORDS*4.
  - If either fires, go directly to RESP with the corresponding flag(s) set. No memory access occurs.
- Legal load: IDLE -> LOAD -> RESP.
  - In LOAD: mem_read=1, mem_address={addr[31:2],00}.
  - mem_read_data is captured at the end of LOAD, lane-selected and extended into a response register.
- Legal word store: IDLE -> WRITE -> RESP.
  - In WRITE: mem_write=1, mem_write_data=wdata.
- Legal byte/half store: IDLE -> RMW_RD -> WRITE -> RESP.
  - RMW_RD: mem_read=1; capture the word and replace the target lane with wdata's low byte or half.
  - WRITE: the merged word is written. All other bytes are preserved.
- Lane selection is little-endian: byte lane = addr[1:0] (lane 0 = bits [7:0]); half lane = addr[1] (0 = [15:0], 1 = [31:16]).
- mem_address stays constant from RMW_RD through WRITE. It is 0 in IDLE and RESP.
- RESP lasts one cycle: resp_valid=1, then return to IDLE. Back-to-back requests are therefore separated by at least one IDLE cycle.
- Latency from acceptance edge to resp_valid:
  - errors: 1 cycle
  - loads: 2 cycles
  - word stores: 2 cycles
  - sub-word stores: 3 cycles
- mem_read and mem_write are never asserted together.
- Both mem_read and mem_write are gated low in any cycle where reset=1, so no write commits on a reset edge.
- Reset mid-operation (any state): return to IDLE. No resp_valid is produced for the aborted request. A partially completed RMW leaves memory unchanged.

Test Plan:
- Reset -> IDLE outputs as listed; req_ready=1. Word store 0x8899AABB to 0x40 -> mem_write=1 for one cycle at mem_address=0x40, resp_valid 2 cycles after accept. Word load from 0x40 -> resp_rdata=0x8899AABB.
- Loads from 0x40 holding 0x8899AABB:
  - signed byte at 0x43 -> 0xFFFFFF88; unsigned byte -> 0x00000088.
  - signed half at 0x42 -> 0xFFFF8899; unsigned half at 0x40 -> 0x0000AABB.
- Byte store 0x11 to 0x41 over 0x8899AABB -> RMW_RD then WRITE, memory becomes 0x889911BB, resp at 3 cycles. Half store 0x2233 to 0x42 -> memory becomes 0x223311BB.
- Misaligned and illegal requests, each expecting resp_misaligned=1 after 1 cycle with mem_read and mem_write never asserted:
  - half load at 0x41
  - word store at 0x42
  - size 11
- Out of range: word load at 0x1000 (MEM_WORDS=1024) -> resp_out_of_range=1, resp_rdata=0, no memory access.
- Reset asserted in WRITE of a byte-store RMW -> mem_write=0 that cycle, target word unchanged, no resp_valid, req_ready=1 next cycle. Hold req_valid high continuously -> exactly one request is accepted per response.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the core's memory-access stage to a word-only data
// memory. Byte/halfword/word loads are lane-extracted and sign/zero-extended;
// sub-word stores use read-modify-write. Misaligned or out-of-range requests
// are reported without any memory access.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_write, req_size      store flag, size (00 byte, 01 half, 10 word, 11 illegal)
//   req_unsigned             loads: zero-extend when 1, sign-extend when 0
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata               extended load data (0 for stores and errors)
//   resp_misaligned          alignment / illegal-size error flag
//   resp_out_of_range        address beyond memory flag
//   mem_read, mem_write      data memory strobes (never both, low during reset)
//   mem_address              word-aligned memory address
//   mem_write_data           word written to memory
//   mem_read_data            combinational read data from memory
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_out_of_range,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned MEM_BYTES = MEM_WORDS * 4;
    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t      state;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        unsigned_q;
    logic [15:0] wdata_q;
    logic        misaligned_c;
    logic        out_of_range_c;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or half of a word, preserving the rest.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic [15:0] data);
        logic [31:0] r;
        if (size == SIZE_BYTE) begin
            case (lane)
                2'd0:    r = {word[31:8], data[7:0]};
                2'd1:    r = {word[31:16], data[7:0], word[7:0]};
                2'd2:    r = {word[31:24], data[7:0], word[15:0]};
                default: r = {data[7:0], word[23:0]};
            endcase
        end else begin
            r = lane[1] ? {data, word[15:0]} : {word[31:16], data};
        end
        return r;
    endfunction

    // Request legality, evaluated on the acceptance cycle.
    always_comb begin
        misaligned_c = 1'b0;
        case (req_size)
            SIZE_BYTE: misaligned_c = 1'b0;
            SIZE_HALF: misaligned_c = req_addr[0];
            SIZE_WORD: misaligned_c = |req_addr[1:0];
            default:   misaligned_c = 1'b1;
        endcase
    end

    assign out_of_range_c = (req_addr >= 32'(MEM_BYTES));

    // Sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            req_ready         <= 1'b1;
            resp_valid        <= 1'b0;
            resp_rdata        <= '0;
            resp_misaligned   <= 1'b0;
            resp_out_of_range <= 1'b0;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_address       <= '0;
            mem_write_data    <= '0;
            size_q            <= '0;
            lane_q            <= '0;
            unsigned_q        <= 1'b0;
            wdata_q           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        size_q     <= req_size;
                        lane_q     <= req_addr[1:0];
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata[15:0];
                        req_ready  <= 1'b0;
                        if (misaligned_c || out_of_range_c) begin
                            state             <= RESP;
                            resp_valid        <= 1'b1;
                            resp_misaligned   <= misaligned_c;
                            resp_out_of_range <= out_of_range_c;
                        end else if (!req_write) begin
                            state       <= LOAD;
                            mem_read_q  <= 1'b1;
                            mem_address <= {req_addr[31:2], 2'b00};
                        end else if (req_size == SIZE_WORD) begin
                            state          <= WRITE;
                            mem_write_q    <= 1'b1;
                            mem_address    <= {req_addr[31:2], 2'b00};
                            mem_write_data <= req_wdata;
                        end else begin
                            state       <= RMW_RD;
                            mem_read_q  <= 1'b1;
                            mem_address <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                LOAD: begin
                    state       <= RESP;
                    mem_read_q  <= 1'b0;
                    mem_address <= '0;
                    resp_valid  <= 1'b1;
                    resp_rdata  <= load_extract(mem_read_data, lane_q, size_q, unsigned_q);
                end
                RMW_RD: begin
                    // Address is held so the write lands on the word just read.
                    state          <= WRITE;
                    mem_read_q     <= 1'b0;
                    mem_write_q    <= 1'b1;
                    mem_write_data <= store_merge(mem_read_data, lane_q, size_q, wdata_q);
                end
                WRITE: begin
                    state          <= RESP;
                    mem_write_q    <= 1'b0;
                    mem_write_data <= '0;
                    mem_address    <= '0;
                    resp_valid     <= 1'b1;
                end
                RESP: begin
                    state             <= IDLE;
                    req_ready         <= 1'b1;
                    resp_valid        <= 1'b0;
                    resp_rdata        <= '0;
                    resp_misaligned   <= 1'b0;
                    resp_out_of_range <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    req_ready   <= 1'b1;
                    resp_valid  <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_address <= '0;
                end
            endcase
        end
    end

    // Strobes are forced low during reset so an aborted write never commits.
    assign mem_read  = mem_read_q & ~reset;
    assign mem_write = mem_write_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a word memory driven by the DUT strobes, a
// transaction-level reference model with its own memory image, and a per-cycle
// compare process checking handshake, memory strobes and responses.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 1024;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_out_of_range;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_misaligned   (resp_misaligned),
        .resp_out_of_range (resp_out_of_range),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical data memory seen by the DUT.
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        mem_clr;
    assign mem_read_data = mem[mem_address[11:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= 32'd0;
        end else if (mem_write) begin
            mem[mem_address[11:2]] <= mem_write_data;
        end
    end

    // Reference memory image maintained by the model.
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    typedef struct {
        int          acc;
        int          rd;
        int          wr;
        int          resp;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic        oor;
        logic        has_lit;
        logic [31:0] lit;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;
    logic chk_en;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (a % (32'd1 << sz)) != 32'd0;
    endfunction

    function automatic logic model_oor(input logic [31:0] a);
        return a >= 32'(MEM_WORDS * 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a);
        logic [31:0] v;
        v = ref_mem[a[11:2]] >> (32'd8 * (a % 32'd4));
        if (sz == 2'b00) begin
            v = v % 32'd256;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            v = v % 32'd65536;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [1:0] sz, input logic [31:0] a,
                                                input logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] sh;
        mask = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        sh   = 32'd8 * (a % 32'd4);
        return (ref_mem[a[11:2]] & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    // Expected timeline and result for a request accepted on the edge after cycle c.
    function automatic exp_t build(input int c, input logic w, input logic [1:0] sz,
                                   input logic uns, input logic [31:0] a,
                                   input logic [31:0] wd, input logic hl,
                                   input logic [31:0] lit);
        exp_t e;
        e.acc     = c + 1;
        e.rd      = -1;
        e.wr      = -1;
        e.addr    = a & 32'hFFFF_FFFC;
        e.wdata   = 32'd0;
        e.rdata   = 32'd0;
        e.mis     = model_mis(sz, a);
        e.oor     = model_oor(a);
        e.has_lit = hl;
        e.lit     = lit;
        if (e.mis || e.oor) begin
            e.resp = c + 1;
        end else if (!w) begin
            e.rd    = c + 1;
            e.resp  = c + 2;
            e.rdata = model_load(sz, uns, a);
        end else if (sz == 2'b10) begin
            e.wr    = c + 1;
            e.resp  = c + 2;
            e.wdata = wd;
            ref_mem[a[11:2]] = wd;
        end else begin
            e.rd    = c + 1;
            e.wr    = c + 2;
            e.resp  = c + 3;
            e.wdata = model_merge(sz, a, wd);
            ref_mem[a[11:2]] = e.wdata;
        end
        return e;
    endfunction

    // Per-cycle comparison against the head of the expectation queue.
    exp_t ce;
    logic have;
    logic ev;
    logic er;
    logic ew;
    always @(negedge clk) begin
        if (chk_en) begin
            have = q.size() > 0;
            if (have) ce = q[0];
            ev = have && (ce.resp == cyc);
            er = have && (ce.rd == cyc);
            ew = have && (ce.wr == cyc);
            chk1("req_ready", req_ready, !(have && ce.acc <= cyc));
            chk1("mem_read", mem_read, er);
            chk1("mem_write", mem_write, ew);
            chk("mem_address", mem_address, (er || ew) ? ce.addr : 32'd0);
            if (ew) chk("mem_write_data", mem_write_data, ce.wdata);
            chk1("resp_valid", resp_valid, ev);
            if (ev) begin
                chk("resp_rdata", resp_rdata, ce.rdata);
                chk1("resp_misaligned", resp_misaligned, ce.mis);
                chk1("resp_out_of_range", resp_out_of_range, ce.oor);
                if (ce.has_lit) chk("resp_literal", resp_rdata, ce.lit);
                void'(q.pop_front());
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d responses outstanding (cycle %0d)", q.size(), cyc);
            q.delete();
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic hl, input logic [31:0] lit);
        @(negedge clk);
        q.push_back(build(cyc, w, sz, uns, a, wd, hl, lit));
        drive(w, sz, uns, a, wd);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();
    endtask

    // Hold req_valid for n edges; a new request is taken each time the unit idles.
    task automatic burst(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int n,
                         input logic [31:0] lit);
        int   c;
        int   a_cyc;
        exp_t e;
        @(negedge clk);
        c = cyc;
        a_cyc = c + 1;
        while (a_cyc <= c + n) begin
            e = build(a_cyc - 1, w, sz, uns, a, wd, 1'b1, lit);
            q.push_back(e);
            a_cyc = e.resp + 2;
        end
        drive(w, sz, uns, a, wd);
        repeat (n) @(negedge clk);
        req_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        reset = 1'b1;
        mem_clr = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("reset_req_ready", req_ready, 1'b1);
        chk1("reset_resp_valid", resp_valid, 1'b0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk1("reset_misaligned", resp_misaligned, 1'b0);
        chk1("reset_out_of_range", resp_out_of_range, 1'b0);
        chk1("reset_mem_read", mem_read, 1'b0);
        chk1("reset_mem_write", mem_write, 1'b0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_mem_write_data", mem_write_data, 32'd0);
        reset = 1'b0;
        mem_clr = 1'b0;
        chk_en = 1'b1;

        // Word store then loads of every lane/extension variant.
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h8899AABB, 1'b1, 32'h0);
        chk("mem_word_store", mem[16], 32'h8899AABB);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'h8899AABB);
        issue(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 1'b1, 32'hFFFFFF88);
        issue(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1'b1, 32'h00000088);
        issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1'b1, 32'hFFFF8899);
        issue(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 1'b1, 32'h0000AABB);
        issue(1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 1'b1, 32'hFFFFFF99);
        issue(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 1'b1, 32'h000000BB);

        // Sub-word read-modify-write stores; upper store-data bits must be ignored.
        issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h00000011, 1'b1, 32'h0);
        chk("mem_byte_store", mem[16], 32'h889911BB);
        issue(1'b1, 2'b01, 1'b0, 32'h42, 32'hFFFF2233, 1'b1, 32'h0);
        chk("mem_half_store", mem[16], 32'h223311BB);

        // Reset while the merged word is being written: nothing commits.
        chk_en = 1'b0;
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h41, 32'h00000055);
        @(negedge clk);
        req_valid = 1'b0;
        chk1("abort_rmw_read", mem_read, 1'b1);
        @(negedge clk);
        chk1("abort_write_before_reset", mem_write, 1'b1);
        reset = 1'b1;
        #1;
        chk1("abort_write_gated", mem_write, 1'b0);
        chk1("abort_read_gated", mem_read, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        chk1("abort_req_ready", req_ready, 1'b1);
        chk1("abort_no_resp", resp_valid, 1'b0);
        chk("abort_mem_address", mem_address, 32'd0);
        @(negedge clk);
        chk1("abort_no_resp_late", resp_valid, 1'b0);
        chk("abort_mem_unchanged", mem[16], 32'h223311BB);
        chk_en = 1'b1;

        // Error cases: flagged after one cycle, no memory traffic.
        issue(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h42, 32'h12345678, 1'b1, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h1003, 32'hAB, 1'b1, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h1001, 32'h0, 1'b1, 32'h0);
        chk("mem_after_errors", mem[16], 32'h223311BB);

        // Top of memory is still in range.
        issue(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, 1'b1, 32'h0);
        chk("mem_top_word", mem[1023], 32'hCAFEF00D);
        issue(1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0, 1'b1, 32'hFFFFFFCA);
        issue(1'b0, 2'b01, 1'b1, 32'hFFE, 32'h0, 1'b1, 32'h0000CAFE);

        // Byte lane 0 store with junk upper data.
        issue(1'b1, 2'b00, 1'b0, 32'h40, 32'hDEADBE77, 1'b1, 32'h0);
        chk("mem_lane0_store", mem[16], 32'h22331177);

        // Continuous req_valid: one acceptance per response (4 loads in 12 edges).
        burst(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 12, 32'h22331177);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
